trig_adc_averager: RTL and testbench

- Front-end acquisition stage of the SPGD loop, clocked by ADC_CLK (250 MHz).
- On each rising edge of the external TRIG_IN (~20 kHz dither/perturbation trigger), it waits a programmable settling delay, then averages 2^NUM_SAMPLES_LOG2 consecutive ADC_IN samples.
- It presents the result as a one-cycle-valid metric to the downstream SPGD gradient/update core that drives DAC_A_OUT/DAC_B_OUT.

---
 rtl/trig_adc_averager.sv | 124 ++++++++++++
 tb/tb_trig_adc_averager.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_adc_averager.sv
// trig_adc_averager: trigger-synchronised ADC acquisition front end.
// After each accepted trigger, waits a settling delay then averages 2^N samples.
module trig_adc_averager #(
   parameter int ADC_WIDTH        = 12,
   parameter int NUM_SAMPLES_LOG2 = 4,
   parameter int DELAY_WIDTH      = 16,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                   ADC_CLK,
   input  logic                   RST,
   input  logic                   EN,
   input  logic                   TRIG_IN,
   input  logic [ADC_WIDTH-1:0]   ADC_IN,
   input  logic [DELAY_WIDTH-1:0] DELAY,
   output logic [ADC_WIDTH-1:0]   METRIC_OUT,
   output logic                   METRIC_VALID,
   output logic                   BUSY,
   output logic                   OVERRUN,
   output logic [COUNT_WIDTH-1:0] TRIG_COUNT
);

   localparam int ACC_W  = ADC_WIDTH + NUM_SAMPLES_LOG2;
   localparam int SCNT_W = NUM_SAMPLES_LOG2 + 1;
   localparam logic [SCNT_W-1:0] LAST_SMP =
      SCNT_W'((1 << NUM_SAMPLES_LOG2) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t state;

   logic                   s1;
   logic                   s2;
   logic                   s3;
   logic                   trig_edge;
   logic [DELAY_WIDTH-1:0] dly_cnt;
   logic [SCNT_W-1:0]      smp_cnt;
   logic [ACC_W-1:0]       acc;
   logic [ACC_W-1:0]       acc_sum;

   assign trig_edge = s2 & ~s3;
   assign acc_sum   = acc + ACC_W'(ADC_IN);

   always_ff @(posedge ADC_CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         dly_cnt      <= '0;
         smp_cnt      <= '0;
         acc          <= '0;
         METRIC_OUT   <= '0;
         METRIC_VALID <= 1'b0;
         BUSY         <= 1'b0;
         OVERRUN      <= 1'b0;
         TRIG_COUNT   <= '0;
      end else begin
         s1           <= TRIG_IN;
         s2           <= s1;
         s3           <= s2;
         METRIC_VALID <= 1'b0;

         // A trigger while busy is flagged but never restarts the acquisition.
         if (trig_edge && state != S_IDLE)
            OVERRUN <= 1'b1;

         unique case (state)
            S_IDLE: begin
               if (trig_edge && EN) begin
                  TRIG_COUNT <= TRIG_COUNT + COUNT_WIDTH'(1);
                  acc        <= '0;
                  smp_cnt    <= '0;
                  BUSY       <= 1'b1;
                  if (DELAY == '0) begin
                     state <= S_ACCUM;
                  end else begin
                     dly_cnt <= DELAY;
                     state   <= S_DELAY;
                  end
               end
            end
            S_DELAY: begin
               if (!EN) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
                  if (dly_cnt == DELAY_WIDTH'(1))
                     state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (!EN) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  acc     <= acc_sum;
                  smp_cnt <= smp_cnt + SCNT_W'(1);
                  // Result is registered on entry so it is visible in DONE.
                  if (smp_cnt == LAST_SMP) begin
                     state        <= S_DONE;
                     METRIC_OUT   <= acc_sum[ACC_W-1 -: ADC_WIDTH];
                     METRIC_VALID <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trig_adc_averager.sv
// tb_trig_adc_averager: randomized self-checking bench for trig_adc_averager.
// Expected timing and averages are derived per trigger from cycle offsets.
module tb_trig_adc_averager;

   localparam int AW = 12;
   localparam int NL = 4;
   localparam int NS = 1 << NL;
   localparam int DW = 16;
   localparam int CW = 4;

   logic          ADC_CLK;
   logic          RST;
   logic          EN;
   logic          TRIG_IN;
   logic [AW-1:0] ADC_IN;
   logic [DW-1:0] DELAY;
   logic [AW-1:0] METRIC_OUT;
   logic          METRIC_VALID;
   logic          BUSY;
   logic          OVERRUN;
   logic [CW-1:0] TRIG_COUNT;

   int vectors     = 0;
   int miscompares = 0;

   logic [AW-1:0] exp_metric;
   logic          exp_overrun;
   logic [CW-1:0] exp_count;

   trig_adc_averager #(
      .ADC_WIDTH       (AW),
      .NUM_SAMPLES_LOG2(NL),
      .DELAY_WIDTH     (DW),
      .COUNT_WIDTH     (CW)
   ) dut (
      .ADC_CLK     (ADC_CLK),
      .RST         (RST),
      .EN          (EN),
      .TRIG_IN     (TRIG_IN),
      .ADC_IN      (ADC_IN),
      .DELAY       (DELAY),
      .METRIC_OUT  (METRIC_OUT),
      .METRIC_VALID(METRIC_VALID),
      .BUSY        (BUSY),
      .OVERRUN     (OVERRUN),
      .TRIG_COUNT  (TRIG_COUNT)
   );

   initial ADC_CLK = 1'b0;
   always #2 ADC_CLK = ~ADC_CLK;

   task automatic step();
      @(posedge ADC_CLK);
      #1;
   endtask

   // Cycle 0: TRIG_IN rises. Edge pulse is seen in cycle e=2, so the
   // DELAY window is e+1..e+d, samples e+d+1..e+d+NS, valid at e+d+NS+1.
   task automatic run_acq(input int d, input int mode, input logic [AW-1:0] k,
                          input int abort_at, input int retrig_at,
                          input int rst_at);
      int            e;
      int            vc;
      int            last;
      int            busy_end;
      int            acc;
      int            idx;
      bit            complete;
      bit            exp_busy;
      bit            exp_valid;
      logic [AW-1:0] s;
      e        = 2;
      vc       = e + d + NS + 1;
      last     = ((retrig_at + 3 > vc) ? retrig_at + 3 : vc) + 3;
      complete = (abort_at < 0) && (rst_at < 0);
      busy_end = (rst_at >= 0) ? rst_at : (abort_at >= 0) ? abort_at : vc;
      acc      = 0;
      DELAY    = DW'(d);
      for (int c = 0; c <= last; c++) begin
         if (c == e + 1)
            exp_count++;
         if (complete && c == vc)
            exp_metric = AW'(acc >> NL);
         if (retrig_at >= 0 && c == retrig_at + 3 &&
             retrig_at + 2 >= e + 1 && retrig_at + 2 <= busy_end)
            exp_overrun = 1'b1;
         if (rst_at >= 0 && c == rst_at + 1) begin
            exp_count   = '0;
            exp_metric  = '0;
            exp_overrun = 1'b0;
         end
         exp_busy  = (c >= e + 1) && (c <= busy_end);
         exp_valid = complete && (c == vc);

         vectors++;
         if (BUSY !== exp_busy) begin
            miscompares++;
            $display("FAIL busy c=%0d d=%0d: got %b want %b", c, d, BUSY, exp_busy);
         end
         vectors++;
         if (METRIC_VALID !== exp_valid) begin
            miscompares++;
            $display("FAIL valid c=%0d d=%0d: got %b want %b",
                     c, d, METRIC_VALID, exp_valid);
         end
         vectors++;
         if (METRIC_OUT !== exp_metric) begin
            miscompares++;
            $display("FAIL metric c=%0d d=%0d: got %h want %h",
                     c, d, METRIC_OUT, exp_metric);
         end
         vectors++;
         if (OVERRUN !== exp_overrun) begin
            miscompares++;
            $display("FAIL overrun c=%0d d=%0d: got %b want %b",
                     c, d, OVERRUN, exp_overrun);
         end
         vectors++;
         if (TRIG_COUNT !== exp_count) begin
            miscompares++;
            $display("FAIL count c=%0d d=%0d: got %0d want %0d",
                     c, d, TRIG_COUNT, exp_count);
         end

         TRIG_IN = (c < 3) ||
                   (retrig_at >= 0 && c >= retrig_at && c < retrig_at + 3);
         EN      = !(abort_at >= 0 && c >= abort_at);
         RST     = (rst_at >= 0 && c == rst_at);
         idx     = c - e - d - 1;
         if (idx < 0 || idx >= NS || mode == 0)
            s = AW'($urandom);
         else if (mode == 1)
            s = k;
         else if (mode == 2)
            s = idx[0] ? 12'h50A : 12'h4FA;
         else
            s = (idx == NS - 1) ? 12'h00F : 12'h000;
         if (idx >= 0 && idx < NS)
            acc += int'(s);
         ADC_IN = s;
         step();
      end
      TRIG_IN = 1'b0;
      EN      = 1'b1;
      RST     = 1'b0;
   endtask

   task automatic test_reset();
      RST     = 1'b1;
      EN      = 1'b0;
      TRIG_IN = 1'b0;
      ADC_IN  = '0;
      DELAY   = '0;
      step();
      step();
      RST         = 1'b0;
      EN          = 1'b1;
      exp_metric  = '0;
      exp_overrun = 1'b0;
      exp_count   = '0;
      vectors++;
      if ({METRIC_OUT, METRIC_VALID, BUSY, OVERRUN, TRIG_COUNT} !== '0) begin
         miscompares++;
         $display("FAIL reset: got m=%h v=%b b=%b o=%b n=%0d want all zero",
                  METRIC_OUT, METRIC_VALID, BUSY, OVERRUN, TRIG_COUNT);
      end
      step();
   endtask

   task automatic test_constant();
      run_acq(10, 1, 12'h523, -1, -1, -1);
   endtask

   task automatic test_averaging();
      run_acq(3, 2, 12'h000, -1, -1, -1);
      run_acq(5, 3, 12'h000, -1, -1, -1);
      run_acq(7, 1, 12'hFFF, -1, -1, -1);
      for (int i = 0; i < 6; i++)
         run_acq(int'($urandom_range(1, 40)), 0, 12'h000, -1, -1, -1);
   endtask

   task automatic test_overrun();
      run_acq(4, 0, 12'h000, -1, 8, -1);
      run_acq(4, 0, 12'h000, -1, -1, -1);
   endtask

   task automatic test_done_overrun();
      run_acq(3, 0, 12'h000, -1, 20, -1);
   endtask

   task automatic test_delay_zero();
      run_acq(0, 1, 12'h523, -1, -1, -1);
      run_acq(0, 0, 12'h000, -1, -1, -1);
   endtask

   task automatic test_en_gating();
      EN = 1'b0;
      for (int c = 0; c < 10; c++) begin
         TRIG_IN = (c < 3);
         ADC_IN  = AW'($urandom);
         step();
         vectors++;
         if (BUSY !== 1'b0 || METRIC_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL gated_busy c=%0d: got b=%b v=%b want 0 0",
                     c, BUSY, METRIC_VALID);
         end
         vectors++;
         if (TRIG_COUNT !== exp_count || OVERRUN !== exp_overrun) begin
            miscompares++;
            $display("FAIL gated_count c=%0d: got n=%0d o=%b want n=%0d o=%b",
                     c, TRIG_COUNT, OVERRUN, exp_count, exp_overrun);
         end
      end
      EN = 1'b1;
      run_acq(6, 1, 12'h523, -1, -1, -1);
      run_acq(6, 0, 12'h000, 13, -1, -1);
      run_acq(10, 0, 12'h000, 6, -1, -1);
   endtask

   task automatic test_reset_mid();
      run_acq(20, 0, 12'h000, -1, -1, 8);
      run_acq(10, 1, 12'h523, -1, -1, -1);
   endtask

   task automatic test_wrap();
      RST = 1'b1;
      step();
      RST         = 1'b0;
      exp_metric  = '0;
      exp_overrun = 1'b0;
      exp_count   = '0;
      for (int i = 0; i < 17; i++)
         run_acq(int'($urandom_range(0, 5)), 0, 12'h000, -1, -1, -1);
      vectors++;
      if (TRIG_COUNT !== 4'd1) begin
         miscompares++;
         $display("FAIL wrap: got %0d want 1", TRIG_COUNT);
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_averaging();
      test_overrun();
      test_done_overrun();
      test_delay_zero();
      test_en_gating();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
